// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared constants for the HD44780 display-side responder.
//   - FSM state encodings (IDLE / FILL / EXEC)
//   - instruction bit masks, decoded by highest set bit
//   - DDRAM line bounds used by the address-counter wrap rule
//   - blank character written by Clear Display
package hd44780_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    // Instruction masks
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    // DDRAM line bounds
    localparam logic [6:0] LINE1_END    = 7'h27;
    localparam logic [6:0] LINE2_START  = 7'h40;
    localparam logic [6:0] ONE_LINE_END = 7'h4F;
    localparam logic [6:0] LINE2_END    = 7'h67;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

endpackage

// File: rtl/hd44780_ac_step.sv
// hd44780_ac_step: combinational next address counter value.
//   ac       in  7  current address counter
//   inc      in  1  1 = step up, 0 = step down
//   two_line in  1  selects the two-line (split) address map
//   ac_next  out 7  stepped address, wrapped into the valid map
// Any value above the map's top address is treated as the top address
// before stepping, so a verbatim out-of-range Set DDRAM address re-enters
// the map on the next step.
module hd44780_ac_step
    import hd44780_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       inc,
    input  logic       two_line,
    output logic [6:0] ac_next
);

    logic [6:0] ac_max;
    logic [6:0] ac_clamped;

    assign ac_max     = two_line ? LINE2_END : ONE_LINE_END;
    assign ac_clamped = (ac > ac_max) ? ac_max : ac;

    always_comb begin
        ac_next = ac_clamped;
        if (inc) begin
            if (two_line && (ac_clamped == LINE1_END)) begin
                ac_next = LINE2_START;
            end else if (ac_clamped == ac_max) begin
                ac_next = 7'h00;
            end else begin
                ac_next = ac_clamped + 7'd1;
            end
        end else begin
            if (two_line && (ac_clamped == LINE2_START)) begin
                ac_next = LINE1_END;
            end else if (ac_clamped == 7'h00) begin
                ac_next = ac_max;
            end else begin
                ac_next = ac_clamped - 7'd1;
            end
        end
    end

endmodule

// File: rtl/hd44780_responder.sv
// hd44780_responder: display-side end of an 8-bit HD44780 parallel bus.
//   clk, rst_n                 clock, asynchronous active-low reset
//   lcd_e/rs/rw, lcd_db_in     bus from the writer (synchronized internally)
//   lcd_db_out, lcd_db_oe      read data and its output enable
//   peek_addr, peek_data       host DDRAM peek port, 1-cycle registered read
//   ac, busy                   address counter and busy flag
//   display_on..two_line       mode flags
//   cmd_strobe/cmd_rs/cmd_byte pulse + contents of each accepted write
//   err_overrun, err_clr       sticky write-while-busy flag and its clear
// Transactions are taken on the falling edge of synchronized E.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int EXEC_CYCLES  = 1850,
    parameter int CLEAR_CYCLES = 76000,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_db_in,
    output logic [7:0] lcd_db_out,
    output logic       lcd_db_oe,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       func_8bit,
    output logic       two_line,
    output logic       cmd_strobe,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       err_overrun,
    input  logic       err_clr
);

    localparam int          BUS_W      = 11;
    localparam logic [31:0] EXEC_LOAD  = 32'(EXEC_CYCLES - 1);
    localparam logic [31:0] CLEAR_LOAD = 32'(CLEAR_CYCLES - 1);

    // Bus synchronizer: {e, rs, rw, db} shifted as one word so all fields
    // come from the same sample.
    logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_reg;
    logic [BUS_W-1:0] bus_s;
    logic             e_s, rs_s, rw_s, e_prev_reg, e_fall;
    logic [7:0]       db_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            e_prev_reg <= 1'b0;
        end else begin
            sync_reg[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_db_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            e_prev_reg <= e_s;
        end
    end

    assign bus_s  = sync_reg[SYNC_STAGES-1];
    assign e_s    = bus_s[10];
    assign rs_s   = bus_s[9];
    assign rw_s   = bus_s[8];
    assign db_s   = bus_s[7:0];
    assign e_fall = e_prev_reg & ~e_s;

    // Control state
    logic [1:0]  state_reg, state_next;
    logic [6:0]  fill_addr_reg, fill_addr_next;
    logic [31:0] exec_cnt_reg, exec_cnt_next;
    logic [6:0]  ac_reg, ac_next;
    logic        display_on_reg, display_on_next;
    logic        cursor_on_reg, cursor_on_next;
    logic        blink_on_reg, blink_on_next;
    logic        entry_inc_reg, entry_inc_next;
    logic        entry_shift_reg, entry_shift_next;
    logic        func_8bit_reg, func_8bit_next;
    logic        two_line_reg, two_line_next;
    logic        cmd_strobe_reg, cmd_strobe_next;
    logic        cmd_rs_reg, cmd_rs_next;
    logic [7:0]  cmd_byte_reg, cmd_byte_next;
    logic        err_overrun_reg, err_overrun_next;

    // DDRAM single write port, shared by FILL and data writes
    logic [7:0] ddram_mem [128];
    logic       ram_we;
    logic [6:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rd_reg;
    logic [7:0] peek_data_reg;

    // One stepper serves data writes, data reads and cursor shift; only a
    // cursor/display-shift instruction overrides the direction.
    logic       step_inc;
    logic [6:0] ac_step_out;
    logic       is_shift_cmd;

    assign is_shift_cmd = ~rs_s & (db_s[7:4] == 4'b0001);
    assign step_inc     = is_shift_cmd ? db_s[2] : entry_inc_reg;

    hd44780_ac_step u_ac_step (
        .ac       (ac_reg),
        .inc      (step_inc),
        .two_line (two_line_reg),
        .ac_next  (ac_step_out)
    );

    always_comb begin
        state_next       = state_reg;
        fill_addr_next   = fill_addr_reg;
        exec_cnt_next    = exec_cnt_reg;
        ac_next          = ac_reg;
        display_on_next  = display_on_reg;
        cursor_on_next   = cursor_on_reg;
        blink_on_next    = blink_on_reg;
        entry_inc_next   = entry_inc_reg;
        entry_shift_next = entry_shift_reg;
        func_8bit_next   = func_8bit_reg;
        two_line_next    = two_line_reg;
        cmd_strobe_next  = 1'b0;
        cmd_rs_next      = cmd_rs_reg;
        cmd_byte_next    = cmd_byte_reg;
        // Set wins over a same-cycle clear (applied below)
        err_overrun_next = err_clr ? 1'b0 : err_overrun_reg;
        ram_we           = 1'b0;
        ram_waddr        = ac_reg;
        ram_wdata        = db_s;

        case (state_reg)
            ST_FILL: begin
                ram_we         = 1'b1;
                ram_waddr      = fill_addr_reg;
                ram_wdata      = BLANK_CHAR;
                fill_addr_next = fill_addr_reg + 7'd1;
                if (fill_addr_reg == 7'h7F) begin
                    state_next    = ST_EXEC;
                    exec_cnt_next = CLEAR_LOAD;
                end
            end
            ST_EXEC: begin
                if (exec_cnt_reg == 32'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    exec_cnt_next = exec_cnt_reg - 32'd1;
                end
            end
            default: begin
            end
        endcase

        if (e_fall) begin
            if (!rw_s) begin
                if (state_reg == ST_IDLE) begin
                    cmd_strobe_next = 1'b1;
                    cmd_rs_next     = rs_s;
                    cmd_byte_next   = db_s;
                    state_next      = ST_EXEC;
                    exec_cnt_next   = EXEC_LOAD;
                    if (rs_s) begin
                        ram_we  = 1'b1;
                        ac_next = ac_step_out;
                    end else if ((db_s & CMD_DDRAM) != 8'h00) begin
                        ac_next = db_s[6:0];
                    end else if ((db_s & CMD_CGRAM) != 8'h00) begin
                        // CGRAM is not modelled; cmd_byte carries the address
                    end else if ((db_s & CMD_FUNC) != 8'h00) begin
                        func_8bit_next = db_s[4];
                        two_line_next  = db_s[3];
                    end else if ((db_s & CMD_SHIFT) != 8'h00) begin
                        // Display shift (b3 = 1) leaves the AC alone
                        if (!db_s[3]) begin
                            ac_next = ac_step_out;
                        end
                    end else if ((db_s & CMD_DISP) != 8'h00) begin
                        display_on_next = db_s[2];
                        cursor_on_next  = db_s[1];
                        blink_on_next   = db_s[0];
                    end else if ((db_s & CMD_ENTRY) != 8'h00) begin
                        entry_inc_next   = db_s[1];
                        entry_shift_next = db_s[0];
                    end else if ((db_s & CMD_HOME) != 8'h00) begin
                        ac_next       = 7'h00;
                        exec_cnt_next = CLEAR_LOAD;
                    end else if ((db_s & CMD_CLEAR) != 8'h00) begin
                        ac_next        = 7'h00;
                        entry_inc_next = 1'b1;
                        state_next     = ST_FILL;
                        fill_addr_next = 7'h00;
                    end
                end else begin
                    err_overrun_next = 1'b1;
                end
            end else if (rs_s && (state_reg == ST_IDLE)) begin
                // Data read completes: advance AC like a data write
                ac_next = ac_step_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_FILL;
            fill_addr_reg   <= 7'h00;
            exec_cnt_reg    <= 32'd0;
            ac_reg          <= 7'h00;
            display_on_reg  <= 1'b0;
            cursor_on_reg   <= 1'b0;
            blink_on_reg    <= 1'b0;
            entry_inc_reg   <= 1'b1;
            entry_shift_reg <= 1'b0;
            func_8bit_reg   <= 1'b1;
            two_line_reg    <= 1'b0;
            cmd_strobe_reg  <= 1'b0;
            cmd_rs_reg      <= 1'b0;
            cmd_byte_reg    <= 8'h00;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fill_addr_reg   <= fill_addr_next;
            exec_cnt_reg    <= exec_cnt_next;
            ac_reg          <= ac_next;
            display_on_reg  <= display_on_next;
            cursor_on_reg   <= cursor_on_next;
            blink_on_reg    <= blink_on_next;
            entry_inc_reg   <= entry_inc_next;
            entry_shift_reg <= entry_shift_next;
            func_8bit_reg   <= func_8bit_next;
            two_line_reg    <= two_line_next;
            cmd_strobe_reg  <= cmd_strobe_next;
            cmd_rs_reg      <= cmd_rs_next;
            cmd_byte_reg    <= cmd_byte_next;
            err_overrun_reg <= err_overrun_next;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ddram_mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peek_data_reg <= 8'h00;
            ram_rd_reg    <= 8'h00;
        end else begin
            peek_data_reg <= ddram_mem[peek_addr];
            ram_rd_reg    <= ddram_mem[ac_reg];
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign lcd_db_oe = e_s & rw_s;
    // Busy data reads return zero; status reads are always allowed
    assign lcd_db_out = !lcd_db_oe ? 8'h00 :
                        rs_s       ? (busy ? 8'h00 : ram_rd_reg) :
                                     {busy, ac_reg};

    assign peek_data   = peek_data_reg;
    assign ac          = ac_reg;
    assign display_on  = display_on_reg;
    assign cursor_on   = cursor_on_reg;
    assign blink_on    = blink_on_reg;
    assign entry_inc   = entry_inc_reg;
    assign entry_shift = entry_shift_reg;
    assign func_8bit   = func_8bit_reg;
    assign two_line    = two_line_reg;
    assign cmd_strobe  = cmd_strobe_reg;
    assign cmd_rs      = cmd_rs_reg;
    assign cmd_byte    = cmd_byte_reg;
    assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_hd44780_responder.sv
// tb_hd44780_responder: directed self-checking bench for hd44780_responder.
module tb_hd44780_responder;

    localparam int EXEC_CYC  = 20;
    localparam int CLEAR_CYC = 60;
    localparam int FILL_BUSY = 128 + CLEAR_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_db_in = 8'h00;
    logic [7:0] lcd_db_out;
    logic       lcd_db_oe;
    logic [6:0] peek_addr = 7'h00;
    logic [7:0] peek_data;
    logic [6:0] ac;
    logic       busy, display_on, cursor_on, blink_on;
    logic       entry_inc, entry_shift, func_8bit, two_line;
    logic       cmd_strobe, cmd_rs;
    logic [7:0] cmd_byte;
    logic       err_overrun;
    logic       err_clr = 1'b0;

    int checks_total  = 0;
    int checks_passed = 0;
    int strobe_cnt    = 0;

    always #5 clk = ~clk;

    hd44780_responder #(
        .EXEC_CYCLES  (EXEC_CYC),
        .CLEAR_CYCLES (CLEAR_CYC),
        .SYNC_STAGES  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_db_in   (lcd_db_in),
        .lcd_db_out  (lcd_db_out),
        .lcd_db_oe   (lcd_db_oe),
        .peek_addr   (peek_addr),
        .peek_data   (peek_data),
        .ac          (ac),
        .busy        (busy),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .entry_inc   (entry_inc),
        .entry_shift (entry_shift),
        .func_8bit   (func_8bit),
        .two_line    (two_line),
        .cmd_strobe  (cmd_strobe),
        .cmd_rs      (cmd_rs),
        .cmd_byte    (cmd_byte),
        .err_overrun (err_overrun),
        .err_clr     (err_clr)
    );

    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] b);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_db_in = b; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        $display("write rs=%0d byte=%02h ac=%02h busy=%0d", rs, b, ac, busy);
    endtask

    task automatic bus_read_begin(input logic rs);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        $display("read  rs=%0d db_out=%02h oe=%0d", rs, lcd_db_out, lcd_db_oe);
    endtask

    task automatic bus_read_end();
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, FILL_BUSY);
    endtask

    task automatic peek(input logic [6:0] a, output logic [7:0] d);
        peek_addr = a;
        @(negedge clk);
        @(negedge clk);
        d = peek_data;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int n_strobe;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_ac", ac, 0);
        check("rst_display_on", display_on, 0);
        check("rst_entry_inc", entry_inc, 1);
        check("rst_func_8bit", func_8bit, 1);
        check("rst_two_line", two_line, 0);
        check("rst_oe", lcd_db_oe, 0);
        check("rst_db_out", lcd_db_out, 8'h00);
        check("rst_err", err_overrun, 0);
        check("rst_strobe", cmd_strobe, 0);
        check("rst_peek", peek_data, 8'h00);

        // Release: FILL then CLEAR busy period
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("init_busy_cycles");
        for (int a = 0; a < 128; a++) begin
            peek(7'(a), d);
            check($sformatf("init_fill[%0d]", a), d, 8'h20);
        end
        check("init_ac", ac, 0);

        // Init sequence and "Wel.:"
        bus_write(1'b0, 8'h0C); wait_idle("idle_0c");
        bus_write(1'b0, 8'h38); wait_idle("idle_38");
        bus_write(1'b0, 8'h01); wait_idle("idle_01");
        bus_write(1'b1, 8'h57); wait_idle("idle_d0");
        bus_write(1'b1, 8'h65); wait_idle("idle_d1");
        bus_write(1'b1, 8'h6C); wait_idle("idle_d2");
        bus_write(1'b1, 8'h2E); wait_idle("idle_d3");
        bus_write(1'b1, 8'h3A); wait_idle("idle_d4");
        check("disp_on", display_on, 1);
        check("cursor_on", cursor_on, 0);
        check("blink_on", blink_on, 0);
        check("two_line", two_line, 1);
        check("func_8bit", func_8bit, 1);
        peek(7'h00, d); check("wel_0", d, 8'h57);
        peek(7'h01, d); check("wel_1", d, 8'h65);
        peek(7'h02, d); check("wel_2", d, 8'h6C);
        peek(7'h03, d); check("wel_3", d, 8'h2E);
        peek(7'h04, d); check("wel_4", d, 8'h3A);
        check("wel_ac", ac, 7'h05);
        check("wel_err", err_overrun, 0);
        check("strobe_count", strobe_cnt, 8);
        check("cmd_rs_last", cmd_rs, 1);
        check("cmd_byte_last", cmd_byte, 8'h3A);

        // Two-line wrap 0x27 -> 0x40
        bus_write(1'b0, 8'hA7); wait_idle("idle_a7");
        check("set_ac_27", ac, 7'h27);
        bus_write(1'b1, 8'h41); wait_idle("idle_41");
        peek(7'h27, d); check("ddram_27", d, 8'h41);
        check("wrap_ac_40", ac, 7'h40);
        bus_write(1'b1, 8'h42); wait_idle("idle_42");
        peek(7'h40, d); check("ddram_40", d, 8'h42);
        check("ac_41", ac, 7'h41);

        // Overrun: second write lands inside the first write's busy window
        bus_write(1'b1, 8'h55);
        n_strobe = strobe_cnt;
        bus_write(1'b1, 8'h66);
        check("ovr_err", err_overrun, 1);
        check("ovr_ac", ac, 7'h42);
        check("ovr_no_strobe", strobe_cnt, n_strobe);
        wait_idle("idle_ovr");
        peek(7'h42, d); check("ovr_ddram", d, 8'h20);
        check("ovr_sticky", err_overrun, 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check("ovr_cleared", err_overrun, 0);

        // Status read while busy, then after busy clears
        bus_write(1'b0, 8'h06);
        bus_read_begin(1'b0);
        check("rd_busy_oe", lcd_db_oe, 1);
        check("rd_busy_val", lcd_db_out, 8'hC2);
        bus_read_end();
        check("rd_oe_drop", lcd_db_oe, 0);
        wait_idle("idle_06");
        bus_read_begin(1'b0);
        check("rd_idle_val", lcd_db_out, 8'h42);
        bus_read_end();

        // Data read returns DDRAM[ac] and advances ac
        bus_write(1'b0, 8'hC1); wait_idle("idle_c1");
        bus_read_begin(1'b1);
        check("rd_data_val", lcd_db_out, 8'h55);
        bus_read_end();
        check("rd_data_ac", ac, 7'h42);

        // Cursor shift, including the 0x40 -> 0x27 boundary
        bus_write(1'b0, 8'h14); wait_idle("idle_14");
        check("shift_r", ac, 7'h43);
        bus_write(1'b0, 8'hC0); wait_idle("idle_c0");
        bus_write(1'b0, 8'h10); wait_idle("idle_10");
        check("shift_l_wrap", ac, 7'h27);

        // One-line map: 0x4F -> 0x00, out-of-range treated as 0x4F
        bus_write(1'b0, 8'h30); wait_idle("idle_30");
        check("one_line", two_line, 0);
        bus_write(1'b0, 8'hCF); wait_idle("idle_cf");
        bus_write(1'b1, 8'h5A); wait_idle("idle_5a");
        peek(7'h4F, d); check("ddram_4f", d, 8'h5A);
        check("wrap_ac_00", ac, 7'h00);
        bus_write(1'b0, 8'hFF); wait_idle("idle_ff");
        check("set_ac_7f", ac, 7'h7F);
        bus_write(1'b0, 8'h10); wait_idle("idle_10b");
        check("oor_dec", ac, 7'h4E);

        // Reset during Clear Display aborts and restarts the fill
        bus_write(1'b0, 8'h01);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midclr_busy", busy, 1);
        check("midclr_ac", ac, 0);
        check("midclr_disp", display_on, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        count_busy("refill_busy_cycles");
        peek(7'h4F, d); check("refill_4f", d, 8'h20);
        peek(7'h00, d); check("refill_00", d, 8'h20);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
